arm_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the shared shifter/ALU datapath for ARM data-processing and branch (B/BL) instructions.
- Sits between the instruction register, the register file and PC on one side and the shift/ALU stage on the other.
- Drives every load-enable, mux-select and opcode that datapath consumes, and evaluates ARM condition codes against the stored NZCV flags.

---
 rtl/arm_multicycle_ctrl_pkg.sv | 53 +++++
 rtl/arm_multicycle_ctrl_if.sv | 38 +++
 rtl/arm_multicycle_ctrl_cond.sv | 34 +++
 rtl/arm_multicycle_ctrl.sv | 117 +++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/arm_multicycle_ctrl_pkg.sv
// rtl/arm_multicycle_ctrl_pkg.sv - shared encodings for the ARM multicycle controller
package arm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WB      = 3'd4,
        ST_BR_LINK = 3'd5,
        ST_BR_EXEC = 3'd6,
        ST_BR_PC   = 3'd7
    } state_t;

    localparam logic [3:0] ADD_OP = 4'b0100;
    localparam logic [3:0] LR_IDX = 4'd14;

    localparam logic [1:0] PC_S_INC    = 2'd0;
    localparam logic [1:0] PC_S_F      = 2'd1;
    localparam logic [1:0] SH_NUM_IMM5 = 2'd0;
    localparam logic [1:0] SH_NUM_RS   = 2'd1;
    localparam logic [1:0] SH_NUM_ROT  = 2'd2;
    localparam logic       RD_S_INST   = 1'b0;
    localparam logic       RD_S_LR     = 1'b1;
    localparam logic       WD_S_F      = 1'b0;
    localparam logic       WD_S_PC     = 1'b1;

    localparam logic [1:0] ALU_CMP_GRP   = 2'b10;
    localparam logic [2:0] SHIFT_ROR_IMM = 3'b110;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // TST/TEQ/CMP/CMN: flags only, no register writeback
    function automatic logic is_compare(input logic [3:0] opcode);
        return opcode[3:2] == ALU_CMP_GRP;
    endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_if.sv
// rtl/arm_multicycle_ctrl_if.sv - controller to datapath control/status bundle
interface arm_multicycle_ctrl_if;
    logic [31:0] Inst;
    logic [3:0]  NZCV;
    logic        Write_IR;
    logic        Write_PC;
    logic [1:0]  PC_s;
    logic        LA;
    logic        LB;
    logic        LC;
    logic        LF;
    logic        S;
    logic        ALU_A_s;
    logic        ALU_B_s;
    logic [3:0]  ALU_OP;
    logic [2:0]  SHIFT_OP;
    logic        Sh_Data_s;
    logic [1:0]  Sh_Num_s;
    logic        Write_Reg;
    logic        Rd_s;
    logic        W_Data_s;
    logic        Undef;
    logic [2:0]  State;

    modport master (
        input  Inst, NZCV,
        output Write_IR, Write_PC, PC_s, LA, LB, LC, LF, S, ALU_A_s, ALU_B_s,
               ALU_OP, SHIFT_OP, Sh_Data_s, Sh_Num_s, Write_Reg, Rd_s, W_Data_s,
               Undef, State
    );

    modport slave (
        output Inst, NZCV,
        input  Write_IR, Write_PC, PC_s, LA, LB, LC, LF, S, ALU_A_s, ALU_B_s,
               ALU_OP, SHIFT_OP, Sh_Data_s, Sh_Num_s, Write_Reg, Rd_s, W_Data_s,
               Undef, State
    );
endinterface

// File: rtl/arm_multicycle_ctrl_cond.sv
// rtl/arm_multicycle_ctrl_cond.sv - ARM condition field evaluation against NZCV
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);
    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/arm_multicycle_ctrl.sv
// rtl/arm_multicycle_ctrl.sv - multicycle FSM sequencing shifter/ALU for data-processing and B/BL
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 Rst,
    arm_multicycle_ctrl_if.master bus
);
    state_t r_state;
    state_t w_next;
    logic   w_cond_pass;
    logic   w_unused_inst;

    assign w_unused_inst = ^{bus.Inst[19:16], bus.Inst[11:7], bus.Inst[3:0]};

    arm_cond_check u_cond (
        .i_cond (bus.Inst[31:28]),
        .i_nzcv (bus.NZCV),
        .o_pass (w_cond_pass)
    );

    assign bus.State = r_state;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.Write_IR  = 1'b0;
        bus.Write_PC  = 1'b0;
        bus.PC_s      = PC_S_INC;
        bus.LA        = 1'b0;
        bus.LB        = 1'b0;
        bus.LC        = 1'b0;
        bus.LF        = 1'b0;
        bus.S         = 1'b0;
        bus.ALU_A_s   = 1'b0;
        bus.ALU_B_s   = 1'b0;
        bus.ALU_OP    = 4'b0000;
        bus.SHIFT_OP  = 3'b000;
        bus.Sh_Data_s = 1'b0;
        bus.Sh_Num_s  = SH_NUM_IMM5;
        bus.Write_Reg = 1'b0;
        bus.Rd_s      = RD_S_INST;
        bus.W_Data_s  = WD_S_F;
        bus.Undef     = 1'b0;
        case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                bus.Write_IR = 1'b1;
                bus.Write_PC = 1'b1;
                bus.PC_s     = PC_S_INC;
                w_next       = ST_DECODE;
            end
            ST_DECODE: begin
                bus.LA = 1'b1;
                bus.LB = 1'b1;
                bus.LC = 1'b1;
                if (!w_cond_pass)                  w_next = ST_FETCH;
                else if (bus.Inst[27:26] == 2'b00) w_next = ST_EXEC;
                else if (bus.Inst[27:25] == 3'b101)
                    w_next = bus.Inst[24] ? ST_BR_LINK : ST_BR_EXEC;
                else begin
                    w_next    = ST_FETCH;
                    bus.Undef = 1'b1;
                end
            end
            ST_EXEC: begin
                bus.ALU_OP = bus.Inst[24:21];
                bus.LF     = 1'b1;
                bus.S      = bus.Inst[20] | is_compare(bus.Inst[24:21]);
                if (bus.Inst[25]) begin
                    bus.Sh_Data_s = 1'b1;
                    bus.Sh_Num_s  = SH_NUM_ROT;
                    bus.SHIFT_OP  = SHIFT_ROR_IMM;
                end else begin
                    bus.SHIFT_OP = bus.Inst[6:4];
                    bus.Sh_Num_s = bus.Inst[4] ? SH_NUM_RS : SH_NUM_IMM5;
                end
                w_next = is_compare(bus.Inst[24:21]) ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                // Rd=PC turns the writeback into a jump through F
                if (bus.Inst[15:12] == 4'd15) begin
                    bus.Write_PC = 1'b1;
                    bus.PC_s     = PC_S_F;
                end else begin
                    bus.Write_Reg = 1'b1;
                    bus.Rd_s      = RD_S_INST;
                    bus.W_Data_s  = WD_S_F;
                end
                w_next = ST_FETCH;
            end
            ST_BR_LINK: begin
                bus.Write_Reg = 1'b1;
                bus.Rd_s      = RD_S_LR;
                bus.W_Data_s  = WD_S_PC;
                w_next        = ST_BR_EXEC;
            end
            ST_BR_EXEC: begin
                bus.ALU_A_s = 1'b1;
                bus.ALU_B_s = 1'b1;
                bus.ALU_OP  = ADD_OP;
                bus.LF      = 1'b1;
                w_next      = ST_BR_PC;
            end
            ST_BR_PC: begin
                bus.Write_PC = 1'b1;
                bus.PC_s     = PC_S_F;
                w_next       = ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb/tb_arm_multicycle_ctrl.sv - directed and random checks of arm_multicycle_ctrl against a phase-trace model
module tb_arm_multicycle_ctrl;
    typedef struct packed {
        logic       write_ir;
        logic       write_pc;
        logic [1:0] pc_s;
        logic       la;
        logic       lb;
        logic       lc;
        logic       lf;
        logic       s;
        logic       alu_a_s;
        logic       alu_b_s;
        logic [3:0] alu_op;
        logic [2:0] shift_op;
        logic       sh_data_s;
        logic [1:0] sh_num_s;
        logic       write_reg;
        logic       rd_s;
        logic       w_data_s;
        logic       undef;
    } out_t;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_WB = 4,
                   P_LINK = 5, P_BR_EXEC = 6, P_BR_PC = 7;

    logic clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   trace[$];
    out_t obs;

    always #5 clk = ~clk;

    arm_multicycle_ctrl_if bus ();

    arm_multicycle_ctrl dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus.master)
    );

    assign obs = {bus.Write_IR, bus.Write_PC, bus.PC_s, bus.LA, bus.LB, bus.LC, bus.LF,
                  bus.S, bus.ALU_A_s, bus.ALU_B_s, bus.ALU_OP, bus.SHIFT_OP, bus.Sh_Data_s,
                  bus.Sh_Num_s, bus.Write_Reg, bus.Rd_s, bus.W_Data_s, bus.Undef};

    // Conditions come in complementary pairs: even code = base predicate, odd = its negation
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    function automatic void build_trace(input logic [31:0] inst, input logic [3:0] f);
        trace = {P_FETCH, P_DECODE};
        if (cond_ok(inst[31:28], f)) begin
            if (inst[27:26] == 2'b00) begin
                trace.push_back(P_EXEC);
                if (inst[24:23] != 2'b10) trace.push_back(P_WB);
            end else if (inst[27:25] == 3'b101) begin
                if (inst[24]) trace.push_back(P_LINK);
                trace.push_back(P_BR_EXEC);
                trace.push_back(P_BR_PC);
            end
        end
    endfunction

    function automatic out_t model_out(input int ph, input logic [31:0] inst, input logic [3:0] f);
        out_t o;
        o = '0;
        case (ph)
            P_FETCH: begin o.write_ir = 1'b1; o.write_pc = 1'b1; end
            P_DECODE: begin
                o.la = 1'b1; o.lb = 1'b1; o.lc = 1'b1;
                o.undef = cond_ok(inst[31:28], f) && inst[27:26] != 2'b00 && inst[27:25] != 3'b101;
            end
            P_EXEC: begin
                o.alu_op = inst[24:21];
                o.lf     = 1'b1;
                o.s      = inst[20] || inst[24:23] == 2'b10;
                if (inst[25]) begin
                    o.sh_data_s = 1'b1; o.sh_num_s = 2'd2; o.shift_op = 3'b110;
                end else begin
                    o.shift_op = inst[6:4];
                    o.sh_num_s = inst[4] ? 2'd1 : 2'd0;
                end
            end
            P_WB: begin
                if (inst[15:12] == 4'd15) begin o.write_pc = 1'b1; o.pc_s = 2'd1; end
                else o.write_reg = 1'b1;
            end
            P_LINK:    begin o.write_reg = 1'b1; o.rd_s = 1'b1; o.w_data_s = 1'b1; end
            P_BR_EXEC: begin o.alu_a_s = 1'b1; o.alu_b_s = 1'b1; o.alu_op = 4'b0100; o.lf = 1'b1; end
            P_BR_PC:   begin o.write_pc = 1'b1; o.pc_s = 2'd1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    task automatic check_phase(input string tag, input int ph, input logic [31:0] inst, input logic [3:0] f);
        check({tag, " state"}, 32'(bus.State), 32'(ph));
        check({tag, " outputs"}, 32'(obs), 32'(model_out(ph, inst, f)));
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge of the next FETCH
    task automatic run_instr(input string name, input logic [31:0] inst, input logic [3:0] f);
        bus.Inst = inst;
        bus.NZCV = f;
        build_trace(inst, f);
        check_phase({name, " c0"}, trace[0], inst, f);
        for (int i = 1; i < trace.size(); i++) begin
            @(posedge clk); @(negedge clk);
            check_phase($sformatf("%s c%0d", name, i), trace[i], inst, f);
        end
        @(posedge clk); @(negedge clk);
        check({name, " back_to_fetch"}, 32'(bus.State), 32'(P_FETCH));
    endtask

    task automatic release_reset(input string tag);
        bit found;
        found = 1'b0;
        Rst = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.State == 3'(P_FETCH)) found = 1'b1;
            else check({tag, " pre_fetch_state"}, 32'(bus.State), 32'(P_IDLE));
        end
        check({tag, " fetch_reached"}, 32'(found), 32'd1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[27:26] = 2'b00;
            1: r[27:25] = 3'b101;
            2: begin r[27:26] = 2'b00; r[24:23] = 2'b10; end
            default: r[27:25] = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b111;
        endcase
        if ($urandom_range(0, 1) != 0) r[31:28] = 4'hE;
        return r;
    endfunction

    initial begin
        bus.Inst = 32'hE0821003;
        bus.NZCV = 4'b0000;
        @(negedge clk);
        check("reset state", 32'(bus.State), 32'(P_IDLE));
        check("reset outputs", 32'(obs), 32'd0);
        @(negedge clk);
        release_reset("rel0");

        run_instr("ADD",       32'hE0821003, 4'b0000);
        run_instr("MOVS_imm",  32'hE3B004FF, 4'b0000);
        run_instr("CMP",       32'hE1510002, 4'b0000);
        run_instr("BEQ_fail",  32'h0A000004, 4'b0000);
        run_instr("BEQ_taken", 32'h0A000004, 4'b0100);
        run_instr("BL",        32'hEB000010, 4'b1011);
        run_instr("MOV_PC",    32'hE1A0F003, 4'b0000);
        run_instr("LDR_undef", 32'hE5901000, 4'b0000);
        run_instr("NV_undef",  32'hF5901000, 4'b1111);
        run_instr("REG_SHIFT", 32'hE0812353, 4'b0000);

        // Asynchronous reset in the middle of EXEC
        bus.Inst = 32'hE0821003;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("midrst exec_state", 32'(bus.State), 32'(P_EXEC));
        Rst = 1'b1;
        #1;
        check("midrst state", 32'(bus.State), 32'(P_IDLE));
        check("midrst outputs", 32'(obs), 32'd0);
        @(posedge clk); @(negedge clk);
        check("midrst held", 32'(bus.State), 32'(P_IDLE));
        release_reset("rel1");

        for (int k = 0; k < 40; k++) begin
            run_instr($sformatf("rnd%0d", k), rand_inst(), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
